tt_um_logic_op_sequencer: RTL and testbench
===========================================

Name: tt_um_logic_op_sequencer

Overview:
Command-driven controller that sequences the team's 8-bit AND/OR selector datapath on a Tiny Tapeout tile.
- Operands A and B are loaded byte-serially over ui_in under a strobe/command protocol on uio_in.
- An EXEC command runs the selected operation with a programmable latency and holds the result on uo_out.
- Optional accumulate mode feeds each result back into A, so AND/OR operations can be chained.

Parameters:
- LATENCY, 2, cycles from EXEC acceptance to result valid; legal range 1..15.
- ACCUM, 1, 1 = write the result back into A and consume B after each EXEC; 0 = operands retained.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- ena  input  1  tile enable; when 0, strobes are ignored
- ui_in  input  8  operand data byte
- uio_in  input  8  [0] strb, [2:1] cmd, [3] op (0 = AND, 1 = OR), [7:4] unused
- uio_out  output  8  [3:0] = 0, [4] busy, [5] res_valid, [6] err, [7] ab_ready (a_vld & b_vld)
- uio_oe  output  8  constant 8'hF0
- uo_out  output  8  result register

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: regA, regB, result = 0; a_vld, b_vld, busy, res_valid, err = 0; strb_q = 0; state IDLE. Consequently uo_out = 0 and uio_out = 0 out of reset.
- Strobe detection: strb_q <= uio_in[0] every cycle. A command is accepted at edge k when uio_in[0] & ~strb_q & ena. A strobe held high therefore yields exactly one command. strb_q tracks uio_in[0] even when ena = 0.
- Commands (cmd encoding): 00 LOAD_A, 01 LOAD_B, 10 EXEC, 11 CLEAR.
- State machine: IDLE, BUSY.
- IDLE, LOAD_A: regA <= ui_in, a_vld <= 1, res_valid <= 0.
- IDLE, LOAD_B: regB <= ui_in, b_vld <= 1, res_valid <= 0.
- IDLE, EXEC with a_vld & b_vld:
  - Latch op, cnt <= LATENCY-1, state <= BUSY, busy = 1 after edge k, res_valid <= 0.
- IDLE, EXEC without both operands: err <= 1, no other effect.
- BUSY: cnt decrements each edge. At the edge where cnt == 0, which is edge k+LATENCY:
  - result <= core output computed from regA, regB and the latched op;
  - res_valid <= 1, busy <= 0, state <= IDLE.
  - If ACCUM = 1, also regA <= same value and b_vld <= 0; a_vld stays 1.
  - busy is therefore high for exactly LATENCY cycles.
- BUSY, LOAD_A / LOAD_B / EXEC: command ignored, err <= 1. The in-flight operation completes unaffected, because regA and regB are frozen while BUSY.
- CLEAR, in any state: all registers return to reset values in the next cycle; an in-flight operation is aborted with no res_valid.
- err is sticky and is cleared only by CLEAR or rst_n.
- ena = 0 mid-operation: the in-flight operation still completes; new strobes are ignored without setting err.
- Reset mid-operation: same result as CLEAR.
- uo_out holds the last result until CLEAR or reset. Later loads do not alter uo_out.
- Simultaneous completion edge and accepted strobe: completion is processed in that cycle and the strobe is treated as arriving while BUSY (err <= 1, command dropped).

Decomposition:
- Package logic_seq_pkg:
  - cmd encodings CMD_LOAD_A, CMD_LOAD_B, CMD_EXEC, CMD_CLEAR;
  - op encodings OP_AND, OP_OR;
  - state enum IDLE / BUSY;
  - uio_out bit-index constants.
- Sub-module logic_sel_core: purely combinational; inputs op, a[7:0], b[7:0]; output y = op ? a|b : a&b.
- Top module contains the strobe detect, FSM, latency counter and register file.

Test Plan:
- LATENCY = 2, ACCUM = 1; LOAD_A 0x14, LOAD_B 0x1E, EXEC op = 0 -> busy high 2 cycles, then uo_out = 0x14, res_valid = 1, b_vld = 0, ab_ready = 0.
- Chain: LOAD_A 0xF0, LOAD_B 0x0F, EXEC OR -> 0xFF; then LOAD_B 0x3C, EXEC AND -> uo_out = 0x3C. Also EXEC with no new LOAD_B -> err = 1, uo_out stays 0x3C.
- strb held high 5 cycles with cmd = LOAD_A and ui_in changing each cycle -> regA takes only the first-cycle value; one command recorded.
- EXEC accepted, then LOAD_A 0xAA strobed while busy -> err = 1; result still computed from the original regA; regA unchanged by the ignored load.
- EXEC, then CLEAR one cycle later -> uo_out = 0, res_valid never asserts, busy = 0, err = 0, a_vld = b_vld = 0.
- ena = 0 with strobes applied -> no state change and err stays 0.
- rst_n low for one cycle mid-BUSY -> all outputs 0 next cycle; uio_oe = 0xF0 throughout.

Source files
------------

// File: rtl/logic_seq_pkg.sv
// Shared encodings for the logic-op sequencer: command codes, operation
// select, FSM states and the bit positions of the status byte on uio_out.
package logic_seq_pkg;

  typedef enum logic [1:0] {
    CMD_LOAD_A = 2'b00,
    CMD_LOAD_B = 2'b01,
    CMD_EXEC   = 2'b10,
    CMD_CLEAR  = 2'b11
  } cmd_e;

  typedef enum logic {
    OP_AND = 1'b0,
    OP_OR  = 1'b1
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Status bit positions inside uio_out; the low nibble is unused (input side).
  localparam int UIO_BUSY_BIT      = 4;
  localparam int UIO_RES_VALID_BIT = 5;
  localparam int UIO_ERR_BIT       = 6;
  localparam int UIO_AB_READY_BIT  = 7;

  // Upper nibble of the bidirectional bus is driven, lower nibble is input.
  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/logic_sel_core.sv
// Combinational AND/OR selector datapath: y = op ? a|b : a&b.
module logic_sel_core
  import logic_seq_pkg::*;
(
  input  op_e        op_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] y_o
);

  // Select bitwise OR or AND of the two operands.
  always_comb begin
    y_o = (op_i == OP_OR) ? (a_i | b_i) : (a_i & b_i);
  end

endmodule

// File: rtl/tt_um_logic_op_sequencer.sv
// Command-driven sequencer around logic_sel_core. Operands are loaded
// byte-serially, EXEC runs the selected op with a fixed latency, and in
// accumulate mode the result is written back into A so ops can be chained.
module tt_um_logic_op_sequencer
  import logic_seq_pkg::*;
#(
  parameter int LATENCY = 2,  // 1..15 cycles from EXEC acceptance to result
  parameter bit ACCUM   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  // Counter preload: completion happens on the edge where the count is 0,
  // which lands exactly LATENCY edges after the EXEC edge.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic       strb_q;
  state_e     state_q,     state_d;
  logic [3:0] cnt_q,       cnt_d;
  op_e        op_q,        op_d;
  logic [7:0] reg_a_q,     reg_a_d;
  logic [7:0] reg_b_q,     reg_b_d;
  logic [7:0] result_q,    result_d;
  logic       a_vld_q,     a_vld_d;
  logic       b_vld_q,     b_vld_d;
  logic       res_valid_q, res_valid_d;
  logic       err_q,       err_d;

  logic       cmd_accept;
  cmd_e       cmd;
  op_e        cmd_op;
  logic [7:0] core_y;

  // The upper four uio_in bits carry no function.
  logic       unused_uio;
  assign unused_uio = &{1'b0, uio_in[7:4]};

  assign cmd        = cmd_e'(uio_in[2:1]);
  assign cmd_op     = op_e'(uio_in[3]);
  assign cmd_accept = uio_in[0] & ~strb_q & ena;

  logic_sel_core u_core (
    .op_i (op_q),
    .a_i  (reg_a_q),
    .b_i  (reg_b_q),
    .y_o  (core_y)
  );

  // Next-state logic: CLEAR has priority in every state, then the FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    reg_a_d     = reg_a_q;
    reg_b_d     = reg_b_q;
    result_d    = result_q;
    a_vld_d     = a_vld_q;
    b_vld_d     = b_vld_q;
    res_valid_d = res_valid_q;
    err_d       = err_q;

    if (cmd_accept && cmd == CMD_CLEAR) begin
      state_d     = IDLE;
      cnt_d       = 4'd0;
      op_d        = OP_AND;
      reg_a_d     = 8'h00;
      reg_b_d     = 8'h00;
      result_d    = 8'h00;
      a_vld_d     = 1'b0;
      b_vld_d     = 1'b0;
      res_valid_d = 1'b0;
      err_d       = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_accept) begin
            unique case (cmd)
              CMD_LOAD_A: begin
                reg_a_d     = ui_in;
                a_vld_d     = 1'b1;
                res_valid_d = 1'b0;
              end
              CMD_LOAD_B: begin
                reg_b_d     = ui_in;
                b_vld_d     = 1'b1;
                res_valid_d = 1'b0;
              end
              CMD_EXEC: begin
                if (a_vld_q && b_vld_q) begin
                  op_d        = cmd_op;
                  cnt_d       = CNT_INIT;
                  state_d     = BUSY;
                  res_valid_d = 1'b0;
                end else begin
                  err_d = 1'b1;
                end
              end
              default: ;  // CLEAR already handled above
            endcase
          end
        end
        BUSY: begin
          // Operands are frozen while busy; any non-CLEAR command is dropped,
          // including one arriving on the completion edge.
          if (cmd_accept) begin
            err_d = 1'b1;
          end
          if (cnt_q == 4'd0) begin
            result_d    = core_y;
            res_valid_d = 1'b1;
            state_d     = IDLE;
            if (ACCUM) begin
              reg_a_d = core_y;
              b_vld_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers. strb_q follows the strobe pin regardless of ena or CLEAR
  // so a strobe held across a CLEAR cannot be seen as a second rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strb_q      <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      op_q        <= OP_AND;
      reg_a_q     <= 8'h00;
      reg_b_q     <= 8'h00;
      result_q    <= 8'h00;
      a_vld_q     <= 1'b0;
      b_vld_q     <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      strb_q      <= uio_in[0];
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      reg_a_q     <= reg_a_d;
      reg_b_q     <= reg_b_d;
      result_q    <= result_d;
      a_vld_q     <= a_vld_d;
      b_vld_q     <= b_vld_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  // Assemble the status byte; busy is simply the FSM being in BUSY.
  always_comb begin
    uio_out                    = 8'h00;
    uio_out[UIO_BUSY_BIT]      = (state_q == BUSY);
    uio_out[UIO_RES_VALID_BIT] = res_valid_q;
    uio_out[UIO_ERR_BIT]       = err_q;
    uio_out[UIO_AB_READY_BIT]  = a_vld_q & b_vld_q;
  end

  assign uio_oe = UIO_OE_MASK;
  assign uo_out = result_q;

endmodule

// File: tb/tb_tt_um_logic_op_sequencer.sv
// Bench for tt_um_logic_op_sequencer (LATENCY=2, ACCUM=1). A cycle-level
// behavioural model tracks operands, result and flags; a compare process
// checks every output each negedge, and directed literals pin key results.
module tb_tt_um_logic_op_sequencer;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  tt_um_logic_op_sequencer #(.LATENCY(LAT), .ACCUM(1'b1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit       m_prev = 1'b0;
  bit [7:0] m_a = 8'h00, m_b = 8'h00, m_res = 8'h00;
  bit       m_av = 1'b0, m_bv = 1'b0, m_rv = 1'b0, m_err = 1'b0, m_op = 1'b0;
  int       m_left = 0;  // edges remaining until the pending result lands

  task automatic model_clear();
    m_a = 8'h00; m_b = 8'h00; m_res = 8'h00;
    m_av = 1'b0; m_bv = 1'b0; m_rv = 1'b0; m_err = 1'b0; m_op = 1'b0;
    m_left = 0;
  endtask

  task automatic model_step();
    bit rising;
    bit accept;
    rising = uio_in[0] && !m_prev;
    accept = rising && ena;
    if (!rst_n) begin
      model_clear();
      m_prev = 1'b0;
    end else begin
      m_prev = uio_in[0];
      if (accept && uio_in[2:1] == 2'd3) begin
        model_clear();
      end else if (m_left > 0) begin
        if (accept) m_err = 1'b1;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_res = m_op ? (m_a | m_b) : (m_a & m_b);
          m_rv  = 1'b1;
          m_a   = m_res;
          m_bv  = 1'b0;
        end
      end else if (accept) begin
        case (uio_in[2:1])
          2'd0: begin m_a = ui_in; m_av = 1'b1; m_rv = 1'b0; end
          2'd1: begin m_b = ui_in; m_bv = 1'b1; m_rv = 1'b0; end
          2'd2: begin
            if (m_av && m_bv) begin
              m_op = uio_in[3]; m_left = LAT; m_rv = 1'b0;
            end else begin
              m_err = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_status();
    return {m_av & m_bv, m_err, m_rv, (m_left > 0), 4'b0000};
  endfunction

  // Model advances on every active edge using the inputs driven before it.
  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: all outputs against the model, every negedge.
  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      check8("uo_out", uo_out, m_res);
      check8("uio_out", uio_out, model_status());
      check8("uio_oe", uio_oe, 8'hF0);
      $display("cycle t=%0t uio_in=%h ui_in=%h ena=%b -> uo_out=%h uio_out=%h",
               $time, uio_in, ui_in, ena, uo_out, uio_out);
    end
  end

  // One-cycle strobe followed by one cycle low.
  task automatic pulse(input logic [1:0] cmd, input logic op, input logic [7:0] data);
    @(negedge clk);
    uio_in = {4'b0000, op, cmd, 1'b1};
    ui_in  = data;
    @(negedge clk);
    uio_in[0] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset
    idle(2);
    rst_n = 1'b1;
    cmp_on = 1'b1;
    idle(1);
    check8("reset_uo", uo_out, 8'h00);
    check8("reset_uio", uio_out, 8'h00);
    check8("reset_oe", uio_oe, 8'hF0);

    // Basic AND: 0x14 & 0x1E = 0x14
    pulse(2'd0, 1'b0, 8'h14);
    pulse(2'd1, 1'b0, 8'h1E);
    pulse(2'd2, 1'b0, 8'h00);
    check8("and_busy_status", uio_out, 8'h90);
    idle(1);
    check8("and_busy_status2", uio_out, 8'h90);
    idle(1);
    check8("and_result", uo_out, 8'h14);
    check8("and_status", uio_out, 8'h20);

    // Chain: F0|0F = FF, then FF & 3C = 3C (ena dropped mid-operation)
    pulse(2'd0, 1'b0, 8'hF0);
    pulse(2'd1, 1'b0, 8'h0F);
    pulse(2'd2, 1'b1, 8'h00);
    idle(2);
    check8("or_result", uo_out, 8'hFF);
    pulse(2'd1, 1'b0, 8'h3C);
    pulse(2'd2, 1'b0, 8'h00);
    ena = 1'b0;
    idle(2);
    ena = 1'b1;
    check8("chain_result", uo_out, 8'h3C);
    check8("chain_status", uio_out, 8'h20);
    pulse(2'd2, 1'b0, 8'h00);
    check8("exec_no_b_status", uio_out, 8'h60);
    check8("exec_no_b_uo", uo_out, 8'h3C);

    // CLEAR, then strobe held 5 cycles with changing data
    pulse(2'd3, 1'b0, 8'h00);
    check8("clear_status", uio_out, 8'h00);
    check8("clear_uo", uo_out, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      uio_in = 8'h01;
      ui_in  = 8'h11 * (i + 1);
    end
    @(negedge clk);
    uio_in = 8'h00;
    pulse(2'd1, 1'b0, 8'hFF);
    pulse(2'd2, 1'b0, 8'h00);
    idle(2);
    check8("held_strobe_result", uo_out, 8'h11);
    check8("held_strobe_status", uio_out, 8'h20);

    // Load while busy (lands on the completion edge): dropped, err set
    pulse(2'd1, 1'b0, 8'h0F);
    pulse(2'd2, 1'b1, 8'h00);
    pulse(2'd0, 1'b0, 8'hAA);
    check8("busy_load_result", uo_out, 8'h1F);
    check8("busy_load_status", uio_out, 8'h60);
    pulse(2'd1, 1'b0, 8'hFF);
    pulse(2'd2, 1'b0, 8'h00);
    idle(2);
    check8("rega_kept", uo_out, 8'h1F);

    // EXEC then CLEAR: aborted, nothing left behind
    pulse(2'd3, 1'b0, 8'h00);
    pulse(2'd0, 1'b0, 8'h5A);
    pulse(2'd1, 1'b0, 8'h3C);
    pulse(2'd2, 1'b0, 8'h00);
    pulse(2'd3, 1'b0, 8'h00);
    check8("abort_uo", uo_out, 8'h00);
    check8("abort_status", uio_out, 8'h00);
    idle(3);
    check8("abort_status_later", uio_out, 8'h00);

    // ena = 0: strobes ignored without error
    ena = 1'b0;
    pulse(2'd0, 1'b0, 8'h77);
    pulse(2'd1, 1'b0, 8'h88);
    pulse(2'd2, 1'b1, 8'h00);
    check8("ena0_status", uio_out, 8'h00);
    check8("ena0_uo", uo_out, 8'h00);
    ena = 1'b1;
    pulse(2'd2, 1'b0, 8'h00);
    check8("ena1_exec_err", uio_out, 8'h40);

    // Reset mid-busy
    pulse(2'd3, 1'b0, 8'h00);
    pulse(2'd0, 1'b0, 8'h33);
    pulse(2'd1, 1'b0, 8'h55);
    pulse(2'd2, 1'b1, 8'h00);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check8("rst_mid_uo", uo_out, 8'h00);
    check8("rst_mid_status", uio_out, 8'h00);
    check8("rst_mid_oe", uio_oe, 8'hF0);
    idle(3);
    check8("rst_mid_later", uio_out, 8'h00);

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
